// File: rtl/pkt_aligned_chan_gate.sv
// Per-chain output gate: samples the channel enable only at packet boundaries,
// so whole packets are either forwarded through a 2-entry skid buffer or dropped and counted.
module pkt_aligned_chan_gate #(
   parameter int WIDTH      = 32,
   parameter int USER_WIDTH = 128,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [WIDTH-1:0]      i_tdata,
   input  logic [USER_WIDTH-1:0] i_tuser,
   input  logic                  i_tlast,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   output logic [WIDTH-1:0]      o_tdata,
   output logic [USER_WIDTH-1:0] o_tuser,
   output logic                  o_tlast,
   output logic                  o_tvalid,
   input  logic                  o_tready,
   output logic                  active,
   output logic [CNT_WIDTH-1:0]  drop_count
);

   localparam int EW = USER_WIDTH + 1 + WIDTH;

   typedef enum logic [1:0] {
      GAP  = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [EW-1:0]         buf_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            occ_q, occ_d;
   logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

   logic full;
   logic fwd;
   logic push;
   logic pop;
   logic drop_last;

   always_comb begin
      full      = (occ_q == 2'd2);
      fwd       = (state_q == PASS) || ((state_q == GAP) && enable);
      i_tready  = 1'b0;
      state_d   = state_q;
      drop_last = 1'b0;

      // Ready never looks at o_tready: only registered occupancy gates passing beats.
      case (state_q)
         GAP:     i_tready = !enable || !full;
         PASS:    i_tready = !full;
         DROP:    i_tready = 1'b1;
         default: i_tready = 1'b0;
      endcase

      push = i_tvalid && i_tready && fwd;
      pop  = (occ_q != 2'd0) && o_tready;

      case (state_q)
         GAP: begin
            if (i_tvalid && i_tready) begin
               if (!i_tlast) begin
                  state_d = enable ? PASS : DROP;
               end else if (!enable) begin
                  drop_last = 1'b1;
               end
            end
         end
         PASS: begin
            if (push && i_tlast) begin
               state_d = GAP;
            end
         end
         DROP: begin
            if (i_tvalid && i_tlast) begin
               drop_last = 1'b1;
               state_d   = GAP;
            end
         end
         default: state_d = GAP;
      endcase

      drop_count_d = drop_count_q;
      if (drop_last && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
         drop_count_d = drop_count_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q      <= GAP;
         occ_q        <= 2'd0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         drop_count_q <= drop_count_d;
         if (push) begin
            wr_ptr_q <= !wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_q[wr_ptr_q] <= {i_tuser, i_tlast, i_tdata};
      end
   end

   assign {o_tuser, o_tlast, o_tdata} = buf_q[rd_ptr_q];
   assign o_tvalid   = (occ_q != 2'd0);
   assign active     = (state_q == PASS);
   assign drop_count = drop_count_q;

endmodule
